matrix_alu_sequencer: RTL

- Command-driven controller that sequences one matrix ALU operation end to end.
- Accepts a command, fetches operand A (and B when needed) from matrix memory, and drives the ALU start/done handshake.
- Writes the 200-bit result back to memory and returns a status response.
- Sits between the host command interface and the ALU plus matrix memory; the ALU is instantiated outside this block.

---
 rtl/matrix_alu_sequencer_pkg.sv | 36 +++
 rtl/matrix_alu_sequencer_if.sv | 49 ++++
 rtl/matrix_alu_sequencer_rd_wait.sv | 33 +++
 rtl/matrix_alu_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_alu_sequencer_pkg.sv
// Shared definitions for the matrix ALU sequencer: opcodes, opcode classes,
// FSM state encoding and the default matrix word width.
package matrix_alu_sequencer_pkg;

    localparam int unsigned MAT_W = 200;

    localparam logic [3:0] OP_ADD       = 4'b0011;
    localparam logic [3:0] OP_SUB       = 4'b0100;
    localparam logic [3:0] OP_MUL       = 4'b0101;
    localparam logic [3:0] OP_TRANSPOSE = 4'b0110;
    localparam logic [3:0] OP_SCALE     = 4'b0111;
    localparam logic [3:0] OP_DET5      = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_WB,
        ST_RESP
    } seq_state_e;

    function automatic logic is_binary(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_DET5);
    endfunction

    // Overflow is only reported for element-wise add and subtract.
    function automatic logic has_overflow(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/matrix_alu_sequencer_if.sv
// Bundle of command, matrix-memory, ALU and response signals around the
// sequencer. master = sequencer side, slave = host/memory/ALU side.
interface matrix_alu_sequencer_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned MAT_W  = 200
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_opcode;
    logic [7:0]        cmd_scalar;
    logic [ADDR_W-1:0] cmd_addr_a;
    logic [ADDR_W-1:0] cmd_addr_b;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [MAT_W-1:0]  mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [MAT_W-1:0]  mem_wr_data;
    logic              alu_start;
    logic [3:0]        alu_opcode;
    logic [7:0]        alu_scalar;
    logic [MAT_W-1:0]  alu_matrix_a;
    logic [MAT_W-1:0]  alu_matrix_b;
    logic [MAT_W-1:0]  alu_result;
    logic              alu_done;
    logic              alu_overflow;
    logic              busy;
    logic              rsp_valid;
    logic              rsp_overflow;
    logic              rsp_error;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_scalar, cmd_addr_a, cmd_addr_b, cmd_addr_r,
        input  mem_rd_data, alu_result, alu_done, alu_overflow,
        output cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output alu_start, alu_opcode, alu_scalar, alu_matrix_a, alu_matrix_b,
        output busy, rsp_valid, rsp_overflow, rsp_error
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_scalar, cmd_addr_a, cmd_addr_b, cmd_addr_r,
        output mem_rd_data, alu_result, alu_done, alu_overflow,
        input  cmd_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  alu_start, alu_opcode, alu_scalar, alu_matrix_a, alu_matrix_b,
        input  busy, rsp_valid, rsp_overflow, rsp_error
    );

endinterface

// File: rtl/matrix_alu_sequencer_rd_wait.sv
// Read-latency counter: capture pulses MEM_LAT cycles after a read strobe,
// the cycle in which the matrix memory presents the requested word.
module matrix_seq_rd_wait #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe,
    output logic capture
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (strobe) begin
            cnt_d = 3'(MEM_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    assign capture = (cnt_q == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_alu_sequencer.sv
// Sequences one matrix ALU operation: operand fetch, ALU handshake, write-back
// and status response. Optional EXEC watchdog enabled by SEQ_WATCHDOG_EN.
module matrix_alu_sequencer #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned MAT_W    = matrix_alu_sequencer_pkg::MAT_W,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned WDOG_CYC = 255
) (
    input logic                    clk,
    input logic                    rst_n,
    matrix_alu_sequencer_if.master bus
);
    import matrix_alu_sequencer_pkg::*;

    if (MEM_LAT < 1 || MEM_LAT > 4 || WDOG_CYC < 1 || WDOG_CYC > 255) begin : g_bad_param
        $error("matrix_alu_sequencer: MEM_LAT or WDOG_CYC out of range");
    end

    seq_state_e        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [7:0]        scalar_q, scalar_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_r_q, addr_r_d;
    logic [MAT_W-1:0]  mat_a_q, mat_a_d, mat_b_q, mat_b_d, res_q, res_d;
    logic              ovf_q, ovf_d, err_q, err_d;
    logic              rd_first_q, rd_first_d, exec_first_q, exec_first_d;
    logic              rd_strobe, rd_capture;
`ifdef SEQ_WATCHDOG_EN
    localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYC - 1);
    logic [7:0]        wdog_q, wdog_d;
`endif

    matrix_seq_rd_wait #(.MEM_LAT(MEM_LAT)) u_rd_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .strobe  (rd_strobe),
        .capture (rd_capture)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        scalar_d     = scalar_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        addr_r_d     = addr_r_q;
        mat_a_d      = mat_a_q;
        mat_b_d      = mat_b_q;
        res_d        = res_q;
        ovf_d        = ovf_q;
        err_d        = err_q;
        rd_first_d   = 1'b0;
        exec_first_d = 1'b0;
`ifdef SEQ_WATCHDOG_EN
        wdog_d       = '0;
`endif
        rd_strobe       = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.alu_start   = 1'b0;
        bus.rsp_valid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d       = bus.cmd_opcode;
                    scalar_d   = bus.cmd_scalar;
                    addr_a_d   = bus.cmd_addr_a;
                    addr_b_d   = bus.cmd_addr_b;
                    addr_r_d   = bus.cmd_addr_r;
                    ovf_d      = 1'b0;
                    err_d      = !is_legal(bus.cmd_opcode);
                    rd_first_d = 1'b1;
                    state_d    = is_legal(bus.cmd_opcode) ? ST_RD_A : ST_RESP;
                end
            end
            ST_RD_A: begin
                rd_strobe       = rd_first_q;
                bus.mem_rd_addr = rd_first_q ? addr_a_q : '0;
                if (rd_capture) begin
                    mat_a_d = bus.mem_rd_data;
                    if (is_binary(op_q)) begin
                        rd_first_d = 1'b1;
                        state_d    = ST_RD_B;
                    end else begin
                        exec_first_d = 1'b1;
                        state_d      = ST_EXEC;
                    end
                end
            end
            ST_RD_B: begin
                rd_strobe       = rd_first_q;
                bus.mem_rd_addr = rd_first_q ? addr_b_q : '0;
                if (rd_capture) begin
                    mat_b_d      = bus.mem_rd_data;
                    exec_first_d = 1'b1;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                bus.alu_start = 1'b1;
`ifdef SEQ_WATCHDOG_EN
                wdog_d = wdog_q + 8'd1;
`endif
                // A done already high on the entry cycle belongs to the previous op.
                if (bus.alu_done && !exec_first_q) begin
                    res_d   = bus.alu_result;
                    ovf_d   = bus.alu_overflow && has_overflow(op_q);
                    state_d = ST_WB;
                end
`ifdef SEQ_WATCHDOG_EN
                else if (wdog_q == WDOG_LIM) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
`endif
            end
            ST_WB: begin
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = addr_r_q;
                state_d         = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_rd_en    = rd_strobe;
    assign bus.mem_wr_data  = res_q;
    assign bus.cmd_ready    = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.alu_opcode   = op_q;
    assign bus.alu_scalar   = scalar_q;
    assign bus.alu_matrix_a = mat_a_q;
    assign bus.alu_matrix_b = mat_b_q;
    assign bus.rsp_overflow = (state_q == ST_RESP) && ovf_q;
    assign bus.rsp_error    = (state_q == ST_RESP) && err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            scalar_q     <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            addr_r_q     <= '0;
            mat_a_q      <= '0;
            mat_b_q      <= '0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            rd_first_q   <= 1'b0;
            exec_first_q <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wdog_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            scalar_q     <= scalar_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            addr_r_q     <= addr_r_d;
            mat_a_q      <= mat_a_d;
            mat_b_q      <= mat_b_d;
            res_q        <= res_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            rd_first_q   <= rd_first_d;
            exec_first_q <= exec_first_d;
`ifdef SEQ_WATCHDOG_EN
            wdog_q       <= wdog_d;
`endif
        end
    end

endmodule
